// File: rtl/arbitro_pkg.sv
// ---------------------------------------------------------------------------
// arbitro_pkg
// Shared definitions for the round-robin arbiter in front of the shared
// register: default requester count, default data width and the arbiter
// FSM state encoding.
// ---------------------------------------------------------------------------
package arbitro_pkg;

   localparam int N_REQ_DEF = 4;
   localparam int WIDTH_DEF = 4;

   typedef enum logic {
      OCIOSO  = 1'b0,
      ESCRITA = 1'b1
   } estado_t;

endpackage

// File: rtl/registrador4bits.sv
// ---------------------------------------------------------------------------
// registrador4bits
// Shared storage register with load enable and synchronous active-low reset.
// Ports:
//   clk     - clock, rising edge
//   rst     - synchronous active-low reset, clears the stored value
//   enable  - load entrada at the next rising edge
//   entrada - value to be stored
//   saida   - current stored value
// ---------------------------------------------------------------------------
module registrador4bits
   import arbitro_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [WIDTH-1:0] entrada,
   output logic [WIDTH-1:0] saida
);

   // Reset has priority over a load so that a write in flight is discarded.
   always_ff @(posedge clk) begin
      if (!rst) begin
         saida <= '0;
      end else if (enable) begin
         saida <= entrada;
      end
   end

endmodule

// File: rtl/arbitro_registrador.sv
// ---------------------------------------------------------------------------
// arbitro_registrador
// Round-robin arbiter granting N_REQ requesters write access to a single
// shared register, one write per cycle.
// Ports:
//   clk           - clock, rising edge
//   rst           - synchronous active-low reset
//   req           - level request per requester (bit i = requester i)
//   dados         - write data, slice [i*WIDTH +: WIDTH] belongs to requester i
//   gnt           - registered one-hot grant, high during the write cycle
//   saida         - content of the shared register
//   dono          - index of the requester of the last completed write
//   ocupado       - high while a write cycle is in progress
//   cont_escritas - number of completed writes, wraps at 256
// ---------------------------------------------------------------------------
module arbitro_registrador
   import arbitro_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ*WIDTH-1:0]   dados,
   output logic [N_REQ-1:0]         gnt,
   output logic [WIDTH-1:0]         saida,
   output logic [$clog2(N_REQ)-1:0] dono,
   output logic                     ocupado,
   output logic [7:0]               cont_escritas
);

   localparam int IW = $clog2(N_REQ);

   estado_t          estado;
   logic [IW-1:0]    vencedor;
   logic [IW-1:0]    ptr;
   logic [N_REQ-1:0] elegiveis;
   logic             achou;
   logic [IW-1:0]    escolha;
   logic [N_REQ-1:0] onehot;
   logic [WIDTH-1:0] entrada;
   logic             enable;
   int               cand;

   // The requester currently being written may not win the following cycle;
   // if it is the only one left the FSM drops to OCIOSO for a cycle and
   // picks it up again from there.
   always_comb begin
      elegiveis = req;
      if (estado == ESCRITA) begin
         elegiveis = req & ~gnt;
      end
   end

   // Round-robin search: scan upward from ptr (last winner + 1), wrapping,
   // and take the first eligible requester.
   always_comb begin
      achou   = 1'b0;
      escolha = '0;
      onehot  = '0;
      cand    = 0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = (int'(ptr) + k) % N_REQ;
         if (!achou && elegiveis[cand]) begin
            achou   = 1'b1;
            escolha = IW'(cand);
         end
      end
      if (achou) begin
         onehot[escolha] = 1'b1;
      end
   end

   // The register loads the winner's slice for the whole write cycle.
   always_comb begin
      enable  = (estado == ESCRITA);
      entrada = dados[vencedor*WIDTH +: WIDTH];
   end

   registrador4bits #(
      .WIDTH (WIDTH)
   ) u_reg (
      .clk     (clk),
      .rst     (rst),
      .enable  (enable),
      .entrada (entrada),
      .saida   (saida)
   );

   // FSM, grant, pointer and write bookkeeping. dono and cont_escritas move
   // on the same edge that loads the register, i.e. the edge closing ESCRITA.
   // The grant decision on that same edge decides between a back-to-back
   // write and returning to OCIOSO.
   always_ff @(posedge clk) begin
      if (!rst) begin
         estado        <= OCIOSO;
         gnt           <= '0;
         vencedor      <= '0;
         ptr           <= '0;
         dono          <= '0;
         ocupado       <= 1'b0;
         cont_escritas <= '0;
      end else begin
         if (estado == ESCRITA) begin
            dono          <= vencedor;
            cont_escritas <= cont_escritas + 8'd1;
         end
         if (achou) begin
            estado   <= ESCRITA;
            gnt      <= onehot;
            vencedor <= escolha;
            ptr      <= IW'((int'(escolha) + 1) % N_REQ);
            ocupado  <= 1'b1;
         end else begin
            estado  <= OCIOSO;
            gnt     <= '0;
            ocupado <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_arbitro_registrador.sv
// ---------------------------------------------------------------------------
// tb_arbitro_registrador
// Directed testbench for arbitro_registrador. Stimulus pushes the expected
// grant and resulting register state into a queue; a monitor pops an entry
// whenever a grant appears and checks the write it produces one cycle later.
// ---------------------------------------------------------------------------
module tb_arbitro_registrador;

   typedef struct {
      logic [3:0] gnt;
      logic [3:0] saida;
      logic [1:0] dono;
      logic [7:0] cont;
   } esperado_t;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [15:0] dados;
   logic [3:0]  gnt;
   logic [3:0]  saida;
   logic [1:0]  dono;
   logic        ocupado;
   logic [7:0]  cont_escritas;

   esperado_t   fila[$];
   int          total = 0;
   int          bad   = 0;

   arbitro_registrador #(
      .N_REQ (4),
      .WIDTH (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req           (req),
      .dados         (dados),
      .gnt           (gnt),
      .saida         (saida),
      .dono          (dono),
      .ocupado       (ocupado),
      .cont_escritas (cont_escritas)
   );

   // Free-running clock, first rising edge at 5.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the flow gets stuck somewhere.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string nome, input logic [31:0] atual,
                              input logic [31:0] exigido);
      total++;
      if (atual !== exigido) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", nome, atual, exigido);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] r, input logic [15:0] d);
      req   = r;
      dados = d;
   endtask

   task automatic pushExpect(input logic [3:0] g, input logic [3:0] s,
                             input logic [1:0] d, input logic [7:0] c);
      esperado_t e;
      e.gnt   = g;
      e.saida = s;
      e.dono  = d;
      e.cont  = c;
      fila.push_back(e);
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Monitor: a grant seen on one falling edge is matched against the queue;
   // on the next falling edge the completed write is checked.
   initial begin
      esperado_t atual;
      bit        pendente;
      pendente = 1'b0;
      forever begin
         @(negedge clk);
         if (pendente) begin
            checkOutput("saida", 32'(saida), 32'(atual.saida));
            checkOutput("dono", 32'(dono), 32'(atual.dono));
            checkOutput("cont_escritas", 32'(cont_escritas), 32'(atual.cont));
            pendente = 1'b0;
         end
         if (gnt !== 4'b0000) begin
            if (fila.size() == 0) begin
               checkOutput("unexpected_gnt", 32'(gnt), 32'h0);
            end else begin
               atual = fila.pop_front();
               checkOutput("gnt", 32'(gnt), 32'(atual.gnt));
               pendente = 1'b1;
            end
         end
      end
   end

   // Directed stimulus.
   initial begin
      rst = 1'b0;
      applyStimulus(4'b1111, 16'h4321);

      // Reset held with every requester active: nothing may be granted.
      tick();
      tick();
      checkOutput("reset_gnt", 32'(gnt), 32'h0);
      checkOutput("reset_saida", 32'(saida), 32'h0);
      checkOutput("reset_cont", 32'(cont_escritas), 32'h0);
      checkOutput("reset_dono", 32'(dono), 32'h0);
      checkOutput("reset_ocupado", 32'(ocupado), 32'h0);

      // Single request from requester 2.
      rst = 1'b1;
      pushExpect(4'b0100, 4'hA, 2'd2, 8'd1);
      applyStimulus(4'b0100, 16'h0A00);
      tick();
      checkOutput("ocupado_write", 32'(ocupado), 32'h1);
      applyStimulus(4'b0000, 16'h0A00);
      tick();
      tick();

      // Fresh pointer, then everyone requests and holds.
      rst = 1'b0;
      tick();
      rst = 1'b1;
      pushExpect(4'b0001, 4'h1, 2'd0, 8'd1);
      pushExpect(4'b0010, 4'h2, 2'd1, 8'd2);
      pushExpect(4'b0100, 4'h3, 2'd2, 8'd3);
      pushExpect(4'b1000, 4'h4, 2'd3, 8'd4);
      pushExpect(4'b0001, 4'h1, 2'd0, 8'd5);
      applyStimulus(4'b1111, 16'h4321);
      repeat (5) tick();
      applyStimulus(4'b0000, 16'h4321);
      tick();

      // Make requester 3 the last winner, then check the wrap to 0.
      pushExpect(4'b1000, 4'h7, 2'd3, 8'd6);
      applyStimulus(4'b1000, 16'h7000);
      tick();
      applyStimulus(4'b0000, 16'h7000);
      tick();
      pushExpect(4'b0001, 4'h5, 2'd0, 8'd7);
      pushExpect(4'b1000, 4'h9, 2'd3, 8'd8);
      applyStimulus(4'b1001, 16'h9005);
      tick();
      tick();
      applyStimulus(4'b0000, 16'h9005);
      tick();

      // Lone requester holding req: one idle cycle between its grants, and
      // data changed while idle is what the second grant writes.
      pushExpect(4'b0010, 4'h6, 2'd1, 8'd9);
      pushExpect(4'b0010, 4'h8, 2'd1, 8'd10);
      applyStimulus(4'b0010, 16'h0060);
      tick();
      tick();
      checkOutput("idle_gap_gnt", 32'(gnt), 32'h0);
      checkOutput("idle_gap_ocupado", 32'(ocupado), 32'h0);
      applyStimulus(4'b0010, 16'h0080);
      tick();
      applyStimulus(4'b0000, 16'h0080);
      tick();
      applyStimulus(4'b0000, 16'h00F0);
      tick();
      checkOutput("dados_no_gnt", 32'(saida), 32'h8);

      // Reset in the middle of a write discards it and clears the pointer.
      pushExpect(4'b0100, 4'h0, 2'd0, 8'd0);
      applyStimulus(4'b0100, 16'h0F00);
      tick();
      rst = 1'b0;
      applyStimulus(4'b0000, 16'h0F00);
      tick();
      checkOutput("midreset_gnt", 32'(gnt), 32'h0);
      checkOutput("midreset_saida", 32'(saida), 32'h0);
      rst = 1'b1;
      pushExpect(4'b0010, 4'hC, 2'd1, 8'd1);
      applyStimulus(4'b1010, 16'h00C0);
      tick();
      applyStimulus(4'b0000, 16'h00C0);
      tick();
      tick();

      // 256 single writes bring the counter back to zero.
      rst = 1'b0;
      tick();
      rst = 1'b1;
      for (int i = 0; i < 256; i++) begin
         pushExpect(4'b0001, 4'(i), 2'd0, 8'(i + 1));
         applyStimulus(4'b0001, {12'h000, 4'(i)});
         tick();
         applyStimulus(4'b0000, {12'h000, 4'(i)});
         tick();
      end
      checkOutput("wrap_cont", 32'(cont_escritas), 32'h0);
      checkOutput("wrap_saida", 32'(saida), 32'hF);

      // Let the monitor drain; a leftover entry is a missing grant.
      for (int w = 0; w < 20 && fila.size() != 0; w++) begin
         tick();
      end
      tick();
      tick();
      checkOutput("missing_gnts", 32'(fila.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
